// File: rtl/spw_timecode_fifo_pio.sv
// SpaceWire time-code capture FIFO with an Avalon-MM PIO register front end.
// Captures in_port on tick_in into a DEPTH-entry FIFO. DATA pops the head, STATUS/CONTROL manage it and LIVE shows in_port.
module spw_timecode_fifo_pio #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  input  logic              tick_in,
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              irq_en_q, irq_en_d;
  logic              cap_en_q, cap_en_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              irq_q, irq_d;

  logic              rd_sel, wr_sel, empty, full;
  logic              pop, push, ovf_ev, flush, mem_we;
  logic [31:0]       status;
  logic              unused_wd;

  assign unused_wd = ^writedata[31:3];
  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign readdata  = readdata_q;
  assign irq       = irq_q;

  always_comb begin
    rd_sel = chipselect & read;
    wr_sel = chipselect & write;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    pop    = rd_sel && (address == 2'd0) && !empty;
    push   = tick_in && cap_en_q && (!full || pop);
    ovf_ev = tick_in && cap_en_q && full && !pop;
    flush  = wr_sel && (address == 2'd2) && writedata[2];
    mem_we = push && !flush;

    status        = '0;
    status[0]     = empty;
    status[1]     = full;
    status[2]     = ovf_q;
    status[8 +: LW] = level_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end

    // A same-cycle overflow event beats a software clear.
    ovf_d = ovf_q;
    if (ovf_ev) ovf_d = 1'b1;
    else if (wr_sel && (address == 2'd1) && writedata[2]) ovf_d = 1'b0;

    irq_en_d = irq_en_q;
    cap_en_d = cap_en_q;
    if (wr_sel && (address == 2'd2)) begin
      irq_en_d = writedata[0];
      cap_en_d = writedata[1];
    end

    readdata_d = '0;
    if (rd_sel) begin
      case (address)
        2'd0:    if (!empty) readdata_d = 32'(mem_q[rd_ptr_q]);
        2'd1:    readdata_d = status;
        2'd2:    readdata_d = {30'd0, cap_en_q, irq_en_q};
        default: readdata_d = 32'(in_port);
      endcase
    end

    irq_d = irq_en_q & (!empty | ovf_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      cap_en_q   <= 1'b0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      cap_en_q   <= cap_en_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  // Storage is not reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= in_port;
  end

endmodule
